// File: rtl/dmem_mmio.sv
// dmem_mmio: rv32is data-memory responder.
// Byte-lane RAM plus a 16-byte I/O page (cycle counter, keyboard FIFO, LEDs).
module dmem_mmio #(
    parameter int          ADDR_WIDTH = 15,
    parameter logic [31:0] RAM_BASE   = 32'h0010_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h0020_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic [2:0]  memop,
    input  logic        we,
    input  logic        re,
    output logic [31:0] dataout,
    input  logic [7:0]  key_data,
    input  logic        key_valid,
    output logic [15:0] leds
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);
    localparam int PW    = $clog2(FIFO_DEPTH);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_RAM  = 2'd1;
    localparam logic [1:0] SRC_MMIO = 2'd2;

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic ram_hit;
    logic mmio_hit;
    logic key_sel;
    logic stat_sel;
    logic led_sel;
    logic wr;
    logic rd;

    assign ram_hit  = addr[31:ADDR_WIDTH] == RAM_BASE[31:ADDR_WIDTH];
    assign mmio_hit = addr[31:4] == MMIO_BASE[31:4];
    assign key_sel  = mmio_hit && addr[3:2] == 2'd1;
    assign stat_sel = mmio_hit && addr[3:2] == 2'd2;
    assign led_sel  = mmio_hit && addr[3:2] == 2'd3;
    assign wr       = we & ~reset;
    assign rd       = re & ~reset;

    logic        is_b;
    logic        is_h;
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        unique case (memop)
            3'b000, 3'b100: is_b = 1'b1;
            3'b001, 3'b101: is_h = 1'b1;
            default: ;
        endcase
    end

    // Store data is replicated so each enabled lane already holds its byte.
    always_comb begin
        be    = 4'hF;
        wdata = datain;
        if (is_b) begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{datain[7:0]}};
        end else if (is_h) begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{datain[15:0]}};
        end
    end

    logic [31:0]           mem [WORDS];
    logic [ADDR_WIDTH-3:0] widx;
    logic [31:0]           ram_q;

    assign widx = addr[ADDR_WIDTH-1:2];

    // Non-blocking read and write on one edge gives read-first behaviour.
    always_ff @(posedge clock) begin
        if (wr && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rd) begin
            ram_q <= mem[widx];
        end
    end

    logic [7:0]  fifo [FIFO_DEPTH];
    logic [PW:0] wptr;
    logic [PW:0] rptr;
    logic [PW:0] count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        pop;
    logic        push;
    logic        ovf_set;

    assign count   = wptr - rptr;
    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign pop     = rd && !we && key_sel && !empty;
    assign push    = key_valid && (!full || pop);
    assign ovf_set = key_valid && full && !pop;

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo[wptr[PW-1:0]] <= key_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (wr && stat_sel) begin
                ovf <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    logic [31:0] cycle;
    logic [15:0] led_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_r <= '0;
        end else if (wr && led_sel) begin
            if (be[0]) led_r[7:0]  <= wdata[7:0];
            if (be[1]) led_r[15:8] <= wdata[15:8];
        end
    end

    assign leds = led_r;

    logic [31:0] stat;
    logic [31:0] mmio_rd;

    always_comb begin
        stat        = '0;
        stat[PW:0]  = count;
        stat[8]     = empty;
        stat[9]     = full;
        stat[10]    = ovf;
    end

    always_comb begin
        mmio_rd = '0;
        unique case (addr[3:2])
            2'd0: mmio_rd = cycle;
            2'd1: mmio_rd = empty ? 32'd0 : {24'd0, fifo[rptr[PW-1:0]]};
            2'd2: mmio_rd = stat;
            2'd3: mmio_rd = {16'd0, led_r};
            default: ;
        endcase
    end

    logic [1:0]  sel_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] mmio_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q  <= SRC_NONE;
            op_q   <= '0;
            off_q  <= '0;
            mmio_q <= '0;
        end else if (rd) begin
            sel_q  <= ram_hit ? SRC_RAM : (mmio_hit ? SRC_MMIO : SRC_NONE);
            op_q   <= memop;
            off_q  <= addr[1:0];
            mmio_q <= mmio_rd;
        end
    end

    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        word = '0;
        unique case (sel_q)
            SRC_RAM:  word = ram_q;
            SRC_MMIO: word = mmio_q;
            default:  word = '0;
        endcase
    end

    assign byte_v = word[{off_q, 3'b000} +: 8];
    assign half_v = off_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        dataout = word;
        unique case (op_q)
            3'b000:  dataout = {{24{byte_v[7]}}, byte_v};
            3'b100:  dataout = {24'd0, byte_v};
            3'b001:  dataout = {{16{half_v[15]}}, half_v};
            3'b101:  dataout = {16'd0, half_v};
            default: dataout = word;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed plus random stimulus against a byte-level
// reference model of RAM, the I/O page and the keyboard queue.
module tb_dmem_mmio;

    localparam logic [31:0] RB = 32'h0010_0000;
    localparam logic [31:0] MB = 32'h0020_0000;
    localparam logic [31:0] UM = 32'h0030_0000;
    localparam int          D  = 8;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] datain = '0;
    logic [2:0]  memop = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] dataout;
    logic [7:0]  key_data = '0;
    logic        key_valid = 1'b0;
    logic [15:0] leds;

    always #5 clock = ~clock;

    dmem_mmio dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .datain   (datain),
        .memop    (memop),
        .we       (we),
        .re       (re),
        .dataout  (dataout),
        .key_data (key_data),
        .key_valid(key_valid),
        .leds     (leds)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  m_ram [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_cyc = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_led = '0;
    logic [31:0] m_dout = '0;

    function automatic bit is_ram(input logic [31:0] x);
        return (x >> 15) == (RB >> 15);
    endfunction

    function automatic bit is_mmio(input logic [31:0] x);
        return (x >> 4) == (MB >> 4);
    endfunction

    function automatic logic [31:0] mword(input logic [1:0] k);
        int n;
        n = m_q.size();
        case (k)
            2'd0: return m_cyc;
            2'd1: return (n > 0) ? {24'd0, m_q[0]} : 32'd0;
            2'd2: return n + ((n == 0) ? 32'h100 : 0)
                         + ((n == D) ? 32'h200 : 0)
                         + (m_ovf ? 32'h400 : 0);
            default: return {16'd0, m_led};
        endcase
    endfunction

    function automatic logic [7:0] mbyte(input logic [31:0] x);
        logic [31:0] w;
        int key;
        if (is_ram(x)) begin
            key = int'(x - RB);
            return m_ram.exists(key) ? m_ram[key] : 8'h00;
        end
        if (is_mmio(x)) begin
            w = mword(x[3:2]) >> (8 * x[1:0]);
            return w[7:0];
        end
        return 8'h00;
    endfunction

    function automatic int sz(input logic [2:0] op);
        if (op == OP_B || op == OP_BU) return 1;
        if (op == OP_H || op == OP_HU) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a,
                                          input logic [2:0] op);
        int n;
        logic [31:0] base;
        logic [31:0] v;
        n = sz(op);
        base = a & ~32'(n - 1);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(mbyte(base + 32'(i))) << (8 * i));
        end
        if (op == OP_B && v[7])  v = v | 32'hFFFF_FF00;
        if (op == OP_H && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] op);
        int n;
        logic [31:0] base;
        logic [31:0] x;
        logic [31:0] b;
        n = sz(op);
        base = a & ~32'(n - 1);
        for (int i = 0; i < n; i++) begin
            x = base + 32'(i);
            b = d >> (8 * i);
            if (is_ram(x)) begin
                m_ram[int'(x - RB)] = b[7:0];
            end else if (is_mmio(x)) begin
                if (x[3:2] == 2'd3 && x[1:0] == 2'd0) m_led[7:0]  = b[7:0];
                if (x[3:2] == 2'd3 && x[1:0] == 2'd1) m_led[15:8] = b[7:0];
                if (x[3:2] == 2'd2) m_ovf = 1'b0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] op,
                        input logic w, input logic r,
                        input logic kv, input logic [7:0] kd);
        bit pop;
        bit full;
        bit dopush;
        @(negedge clock);
        reset = rst;
        addr = a;
        datain = d;
        memop = op;
        we = w;
        re = r;
        key_valid = kv;
        key_data = kd;
        @(posedge clock);
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_led = '0;
            m_cyc = '0;
            m_dout = '0;
        end else begin
            if (r) m_dout = mload(a, op);
            pop = r && !w && is_mmio(a) && a[3:2] == 2'd1 && m_q.size() > 0;
            full = m_q.size() == D;
            dopush = 1'b0;
            if (w) mstore(a, d, op);
            if (kv) begin
                if (!full || pop) dopush = 1'b1;
                else m_ovf = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (dopush) m_q.push_back(kd);
            m_cyc = m_cyc + 1;
        end
        #1;
        chk("dout", dataout, m_dout);
        chk("leds", 32'(leds), 32'(m_led));
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] op);
        step(1'b0, a, 32'd0, op, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op);
        step(1'b0, a, d, op, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic kpush(input logic [7:0] kd);
        step(1'b0, 32'd0, 32'd0, OP_W, 1'b0, 1'b0, 1'b1, kd);
    endtask

    initial begin
        logic [31:0] a;
        int cls;

        step(1'b1, 0, 0, OP_W, 0, 0, 0, 0);
        step(1'b1, 0, 0, OP_W, 0, 0, 0, 0);
        chk("rst_dout", dataout, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);

        for (int i = 0; i < 9; i++) step(1'b0, 0, 0, OP_W, 0, 0, 0, 0);
        ld(MB, OP_W);
        chk("cycle", dataout, 32'd9);

        st(RB + 32'h10, 32'h8765_4321, OP_W);
        ld(RB + 32'h13, OP_B);
        chk("lb", dataout, 32'hFFFF_FF87);
        ld(RB + 32'h13, OP_BU);
        chk("lbu", dataout, 32'h0000_0087);
        ld(RB + 32'h12, OP_H);
        chk("lh", dataout, 32'hFFFF_8765);
        ld(RB + 32'h10, OP_HU);
        chk("lhu", dataout, 32'h0000_4321);
        ld(RB + 32'h10, OP_W);
        chk("lw", dataout, 32'h8765_4321);

        st(RB + 32'h11, 32'h0000_00AA, OP_B);
        ld(RB + 32'h10, OP_W);
        chk("sb_lane", dataout, 32'h8765_AA21);
        st(RB + 32'h12, 32'h0000_1234, OP_H);
        ld(RB + 32'h10, OP_W);
        chk("sh_lane", dataout, 32'h1234_AA21);

        step(1'b0, RB + 32'h10, 32'hCAFE_F00D, OP_W, 1, 1, 0, 0);
        chk("rd_first", dataout, 32'h1234_AA21);
        ld(RB + 32'h10, OP_W);
        chk("rd_new", dataout, 32'hCAFE_F00D);
        ld(UM, OP_W);
        chk("unmapped_ld", dataout, 32'd0);
        st(UM + 32'h10, 32'hDEAD_BEEF, OP_W);
        ld(RB + 32'h10, OP_W);
        chk("unmapped_st", dataout, 32'hCAFE_F00D);

        kpush(8'h1C);
        kpush(8'h32);
        ld(MB + 8, OP_W);
        chk("stat2", dataout, 32'h002);
        ld(MB + 4, OP_W);
        chk("key1", dataout, 32'h1C);
        ld(MB + 4, OP_W);
        chk("key2", dataout, 32'h32);
        ld(MB + 4, OP_W);
        chk("key_empty", dataout, 32'd0);
        ld(MB + 8, OP_W);
        chk("stat_empty", dataout, 32'h100);
        for (int i = 0; i < 9; i++) kpush(8'h40 + 8'(i));
        ld(MB + 8, OP_W);
        chk("stat_ovf", dataout, 32'h608);
        st(MB + 8, 32'd0, OP_W);
        ld(MB + 8, OP_W);
        chk("stat_clr", dataout, 32'h208);

        step(1'b0, MB + 4, 0, OP_W, 0, 1, 1, 8'h77);
        chk("full_pop", dataout, 32'h40);
        ld(MB + 8, OP_W);
        chk("full_pp", dataout, 32'h208);
        step(1'b0, MB + 4, 0, OP_W, 1, 1, 0, 0);
        ld(MB + 8, OP_W);
        chk("rw_nopop", dataout, 32'h208);
        for (int i = 0; i < 8; i++) ld(MB + 4, OP_W);
        chk("drain_last", dataout, 32'h77);

        st(MB + 12, 32'h0000_BEEF, OP_H);
        chk("led", 32'(leds), 32'h0000_BEEF);
        ld(MB + 12, OP_W);
        chk("led_rd", dataout, 32'h0000_BEEF);

        kpush(8'h55);
        ld(RB + 32'h10, OP_W);
        step(1'b1, MB + 12, 32'h0000_1234, OP_W, 1, 0, 1, 8'h66);
        chk("rst_led", 32'(leds), 32'd0);
        chk("rst_dout2", dataout, 32'd0);
        step(1'b1, RB + 32'h10, 32'h1111_1111, OP_W, 1, 0, 0, 0);
        ld(MB + 8, OP_W);
        chk("rst_fifo", dataout, 32'h100);
        ld(RB + 32'h10, OP_W);
        chk("rst_nost", dataout, 32'hCAFE_F00D);

        for (int i = 0; i < 64; i++) st(RB + 32'(4 * i), $urandom, OP_W);
        for (int i = 0; i < 300; i++) begin
            cls = $urandom_range(0, 99);
            if (cls < 50)      a = RB + 32'($urandom_range(0, 255));
            else if (cls < 85) a = MB + 32'($urandom_range(0, 15));
            else               a = UM + 32'($urandom_range(0, 255));
            step($urandom_range(0, 49) == 0, a, $urandom,
                 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
